// File: rtl/spi_master_shifter_if.sv
// Host-side and SPI-side signals of spi_master_shifter, grouped into one bundle.
// master: the serialiser itself; slave: the host/peripheral environment driving it.
interface spi_master_shifter_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_shifter.sv
// Mode-0 SPI master serialiser with internally divided SCLK, all on clk_in.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first bit order (default MSB first).
module spi_master_shifter #(
    parameter int DIV_FACTOR = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    spi_master_shifter_if.master bus
);
    localparam int CNT_W = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV_FACTOR - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_tx_first;
    logic                  w_tx_next;
    logic [DATA_WIDTH-1:0] w_tx_shifted;
    logic [DATA_WIDTH-1:0] w_rx_shifted;

    assign w_tick = (r_cnt == CNT_MAX);

`ifdef SPI_LSB_FIRST_EN
    assign w_tx_first   = bus.tx_data[0];
    assign w_tx_next    = r_tx[1];
    assign w_tx_shifted = r_tx >> 1;
    assign w_rx_shifted = {bus.miso, r_rx[DATA_WIDTH-1:1]};
`else
    assign w_tx_first   = bus.tx_data[DATA_WIDTH-1];
    assign w_tx_next    = r_tx[DATA_WIDTH-2];
    assign w_tx_shifted = r_tx << 1;
    assign w_rx_shifted = {r_rx[DATA_WIDTH-2:0], bus.miso};
`endif

    // NOTE: all state, including the data shift registers, is cleared by the async reset so
    // an aborted transfer leaves nothing behind; every register here uses non-blocking updates.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_tx    <= bus.tx_data;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_mosi  <= w_tx_first;
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_rx    <= w_rx_shifted;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_rx <= w_rx_shifted;
                        end else begin
                            // Falling toggle: the last bit stays on mosi through TRAIL.
                            r_bit <= r_bit + 1'b1;
                            if (r_bit == LAST_BIT) begin
                                r_state <= S_TRAIL;
                            end else begin
                                r_mosi <= w_tx_next;
                                r_tx   <= w_tx_shifted;
                            end
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_rx_data <= r_rx;
                        r_cs_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sclk    = r_sclk;
    assign bus.mosi    = r_mosi;
    assign bus.cs_n    = r_cs_n;
endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: a DIV_FACTOR=4 and a DIV_FACTOR=1 instance,
// checked edge by edge against a bit-order/edge-number model of the SPI transfer.
module tb_spi_master_shifter;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    bit   sel;       // 0: DIV_FACTOR=4 instance, 1: DIV_FACTOR=1 instance
    bit   loop;      // miso = mosi when set
    logic miso_drv;

    spi_master_shifter_if #(.DATA_WIDTH(W)) if4 ();
    spi_master_shifter_if #(.DATA_WIDTH(W)) if1 ();

    spi_master_shifter #(.DIV_FACTOR(4), .DATA_WIDTH(W)) dut4 (
        .clk_in (clk),
        .rst    (rst),
        .bus    (if4.master)
    );

    spi_master_shifter #(.DIV_FACTOR(1), .DATA_WIDTH(W)) dut1 (
        .clk_in (clk),
        .rst    (rst),
        .bus    (if1.master)
    );

    assign if4.miso = loop ? if4.mosi : miso_drv;
    assign if1.miso = loop ? if1.mosi : miso_drv;

    logic         o_sclk, o_mosi, o_cs_n, o_busy, o_done;
    logic [W-1:0] o_rx;
    assign o_sclk = sel ? if1.sclk    : if4.sclk;
    assign o_mosi = sel ? if1.mosi    : if4.mosi;
    assign o_cs_n = sel ? if1.cs_n    : if4.cs_n;
    assign o_busy = sel ? if1.busy    : if4.busy;
    assign o_done = sel ? if1.done    : if4.done;
    assign o_rx   = sel ? if1.rx_data : if4.rx_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [W-1:0] d);
        if (sel) begin
            if1.start   = s;
            if1.tx_data = d;
        end else begin
            if4.start   = s;
            if4.tx_data = d;
        end
    endtask

    // k-th transmitted bit of a word, and the rx_data position of the k-th received bit.
    function automatic logic tx_bit(input logic [W-1:0] tx, input int k);
`ifdef SPI_LSB_FIRST_EN
        return tx[k];
`else
        return tx[W-1-k];
`endif
    endfunction

    function automatic int rx_pos(input int k);
`ifdef SPI_LSB_FIRST_EN
        return k;
`else
        return W - 1 - k;
`endif
    endfunction

    task automatic kick(input logic [W-1:0] tx, input bit hold);
        drive(1'b1, tx);
        @(posedge clk); #1;
        check("accept_cs_n", o_cs_n, 0);
        check("accept_busy", o_busy, 1);
        check("accept_first_mosi", o_mosi, tx_bit(tx, 0));
        if (!hold) drive(1'b0, tx);
    endtask

    // Runs from edge 1 to the done edge of a transfer already accepted at edge 0.
    // miso_mode: 0 random, 1 tied high (ignored when loop is set).
    task automatic observe(input int div, input logic [W-1:0] tx, input int miso_mode,
                           input int pulse_edge, input bit hold);
        int           n;
        int           rises, bad_timing, bad_mosi, bad_ctrl, k;
        bit           is_rise, is_fall;
        logic         mb, prev_sclk, prev_mosi;
        logic [W-1:0] exp_rx, exp_seq, obs_seq;
        n = (2 * W + 1) * div;
        rises = 0; bad_timing = 0; bad_mosi = 0; bad_ctrl = 0;
        exp_rx = '0; obs_seq = '0;
        for (int i = 0; i < W; i++) exp_seq[i] = tx_bit(tx, i);
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
        for (int e = 1; e <= n; e++) begin
            mb = (miso_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            miso_drv = mb;
            if (!hold) drive(e == pulse_edge, (e == pulse_edge) ? W'(8'hFF) : W'($urandom));
            @(posedge clk); #1;
            is_rise = (e % (2 * div) == div) && (e < n);
            is_fall = (e % (2 * div) == 0);
            if (is_rise) begin
                k = (e - div) / (2 * div);
                exp_rx[rx_pos(k)] = loop ? tx_bit(tx, k) : mb;
                obs_seq[k] = o_mosi;
            end
            if (o_sclk && !prev_sclk) begin
                rises++;
                if (!is_rise) bad_timing++;
            end
            if (!o_sclk && prev_sclk && !is_fall) bad_timing++;
            if (o_sclk === prev_sclk && (is_rise || is_fall)) bad_timing++;
            if (o_mosi !== prev_mosi && !is_fall && e != n) bad_mosi++;
            if (o_done && e != n) bad_ctrl++;
            if (e < n && (o_busy !== 1'b1 || o_cs_n !== 1'b0)) bad_ctrl++;
            prev_sclk = o_sclk;
            prev_mosi = o_mosi;
        end
        check("sclk_rise_count", rises, W);
        check("sclk_edge_timing", bad_timing, 0);
        check("mosi_sequence", obs_seq, exp_seq);
        check("mosi_change_off_fall", bad_mosi, 0);
        check("busy_cs_early_done", bad_ctrl, 0);
        check("done_pulse", o_done, 1);
        check("done_busy_low", o_busy, 0);
        check("done_cs_n_high", o_cs_n, 1);
        check("done_sclk_idle", o_sclk, 0);
        check("done_mosi_low", o_mosi, 0);
        check("rx_data", o_rx, exp_rx);
    endtask

    initial begin
        int           bad;
        logic [W-1:0] t;
        rst = 1'b1;
        sel = 1'b0; loop = 1'b0; miso_drv = 1'b0;
        if4.start = 1'b0; if4.tx_data = '0;
        if1.start = 1'b0; if1.tx_data = '0;
        #23;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            check("rst_cs_n", o_cs_n, 1);
            check("rst_sclk", o_sclk, 0);
            check("rst_mosi", o_mosi, 0);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_rx_data", o_rx, 0);
        end
        sel = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Loopback 0xA5
        loop = 1'b1;
        kick(8'hA5, 1'b0);
        observe(4, 8'hA5, 0, -1, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", o_done, 0);

        // miso tied high, tx 0x00
        loop = 1'b0;
        kick(8'h00, 1'b0);
        observe(4, 8'h00, 1, -1, 1'b0);

        // start pulse during a transfer is ignored
        loop = 1'b1;
        kick(8'hA5, 1'b0);
        observe(4, 8'hA5, 0, 20, 1'b0);
        bad = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (o_done !== 1'b0 || o_cs_n !== 1'b1) bad++;
        end
        check("no_queued_start", bad, 0);

        // Random words against random miso
        loop = 1'b0;
        for (int r = 0; r < 3; r++) begin
            t = W'($urandom);
            kick(t, 1'b0);
            observe(4, t, 0, -1, 1'b0);
        end

        // Reset mid-transfer
        loop = 1'b1;
        kick(8'h5A, 1'b0);
        for (int e = 1; e < 30; e++) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs_n", o_cs_n, 1);
        check("midrst_sclk", o_sclk, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_mosi", o_mosi, 0);
        bad = 0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            if (o_done !== 1'b0 || o_cs_n !== 1'b1) bad++;
        end
        @(negedge clk) rst = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (o_done !== 1'b0 || o_cs_n !== 1'b1) bad++;
        end
        check("midrst_no_done", bad, 0);
        kick(8'h3C, 1'b0);
        observe(4, 8'h3C, 0, -1, 1'b0);

        // Back-to-back with start held high
        kick(8'h12, 1'b1);
        drive(1'b1, 8'h34);
        observe(4, 8'h12, 0, -1, 1'b1);
        @(posedge clk); #1;
        check("b2b_accept_cs_n", o_cs_n, 0);
        check("b2b_accept_busy", o_busy, 1);
        check("b2b_first_mosi", o_mosi, tx_bit(8'h34, 0));
        drive(1'b0, 8'h34);
        observe(4, 8'h34, 0, -1, 1'b0);

        // DIV_FACTOR=1 instance
        @(posedge clk); #1;
        sel = 1'b1;
        loop = 1'b1;
        kick(8'h01, 1'b0);
        observe(1, 8'h01, 0, -1, 1'b0);
        loop = 1'b0;
        for (int r = 0; r < 2; r++) begin
            t = W'($urandom);
            kick(t, 1'b0);
            observe(1, t, 0, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
